// File: rtl/data_ram_responder.sv
// 256-bit word RAM responder: zero-fills every word after reset (INIT), then serves pipelined reads and byte-masked writes.
// Optional macro RAM_RESPONDER_WR_FWD_EN: a read colliding with a same-cycle write to its address returns the merged new data.
module data_ram_responder #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rden_RAM,
    input  logic         wren_RAM,
    input  logic [13:0]  address_RAM,
    input  logic [31:0]  byteena_RAM,
    input  logic [255:0] writeData_RAM,
    output logic [255:0] readData_RAM,
    output logic         rvalid_RAM,
    output logic         ready_RAM,
    output logic         err_RAM
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} stateT;

    stateT         state;
    stateT         nextState;
    logic [AW-1:0] initPtr;
    logic          initWrite;
    logic          readAccept;
    logic          writeAccept;
    logic          inRange;
    logic [AW-1:0] memIdx;
    logic [255:0]  memWord;
    logic [255:0]  mergedWord;
    logic [255:0]  readValue;
    logic [255:0]  mem [DEPTH];

    logic [READ_LATENCY-1:0] validPipe;
    logic [255:0]            dataPipe [READ_LATENCY];

    // The INIT pointer walks every word once, wrapping back to 0 as RUN begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            initPtr <= '0;
        end else begin
            state <= nextState;
            if (state == INIT)
                initPtr <= initPtr + AW'(1);
        end
    end

    always_comb begin
        nextState = state;
        ready_RAM = 1'b0;
        initWrite = 1'b0;
        case (state)
            INIT: begin
                initWrite = 1'b1;
                if (initPtr == LAST_WORD)
                    nextState = RUN;
            end
            RUN: ready_RAM = 1'b1;
            default: nextState = INIT;
        endcase
    end

    assign readAccept  = ready_RAM & rden_RAM;
    assign writeAccept = ready_RAM & wren_RAM;
    assign inRange     = (32'(address_RAM) < 32'(DEPTH));
    assign memIdx      = address_RAM[AW-1:0];
    assign memWord     = mem[memIdx];

    always_comb begin
        mergedWord = memWord;
        for (int b = 0; b < 32; b++)
            if (byteena_RAM[b])
                mergedWord[8*b +: 8] = writeData_RAM[8*b +: 8];
    end

`ifdef RAM_RESPONDER_WR_FWD_EN
    assign readValue = !inRange ? '0 : (writeAccept ? mergedWord : memWord);
`else
    assign readValue = inRange ? memWord : '0;
`endif

    // Storage has no reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (initWrite)
            mem[initPtr] <= '0;
        else if (writeAccept && inRange)
            mem[memIdx] <= mergedWord;
    end

    // Each stage only loads when valid data moves in, so the last stage holds the previous response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validPipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                dataPipe[i] <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                validPipe[i] <= validPipe[i-1];
                if (validPipe[i-1])
                    dataPipe[i] <= dataPipe[i-1];
            end
            validPipe[0] <= readAccept;
            if (readAccept)
                dataPipe[0] <= readValue;
        end
    end

    assign rvalid_RAM   = validPipe[READ_LATENCY-1];
    assign readData_RAM = dataPipe[READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_RAM <= 1'b0;
        else if ((readAccept || writeAccept) && !inRange)
            err_RAM <= 1'b1;
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder (DEPTH=256, READ_LATENCY=3): directed vectors push expected
// read data and arrival cycle; a negedge monitor pops and compares on every rvalid pulse.
module tb_data_ram_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         rden;
    logic         wren;
    logic [13:0]  addr;
    logic [31:0]  be;
    logic [255:0] wdata;
    logic [255:0] readData;
    logic         rvalid;
    logic         ready;
    logic         err;

    typedef struct {
        logic [255:0] data;
        int           due;
    } expT;

    expT          sbQ[$];
    expT          monEntry;
    int           cycleCount = 0;
    int           vectorsApplied = 0;
    int           miscompares = 0;
    int           initCycles;
    logic [255:0] collideExp;
    logic [255:0] word3;
    logic [255:0] word1;
    logic [255:0] word8;

    data_ram_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .rden_RAM(rden),
        .wren_RAM(wren),
        .address_RAM(addr),
        .byteena_RAM(be),
        .writeData_RAM(wdata),
        .readData_RAM(readData),
        .rvalid_RAM(rvalid),
        .ready_RAM(ready),
        .err_RAM(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount = cycleCount + 1;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [13:0] a,
                                 input logic [31:0] b, input logic [255:0] d, input logic [255:0] expRead);
        expT e;
        @(posedge clk);
        #1;
        rden  = rd;
        wren  = wr;
        addr  = a;
        be    = b;
        wdata = d;
        if (rd) begin
            e.data = expRead;
            e.due  = cycleCount + LAT;
            sbQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rden = 1'b0;
            wren = 1'b0;
            addr = '0;
            be   = '0;
            wdata = '0;
        end
    endtask

    task automatic waitInit();
        initCycles = 0;
        @(negedge clk);
        while (ready !== 1'b1 && initCycles < 400) begin
            initCycles++;
            @(negedge clk);
        end
        checkOutput("init length", 256'(initCycles), 256'(DEPTH));
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected rvalid", 256'(rvalid), 256'(0));
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("read data", readData, monEntry.data);
                checkOutput("read latency", 256'(cycleCount), 256'(monEntry.due));
            end
        end else if (sbQ.size() > 0 && cycleCount > sbQ[0].due) begin
            monEntry = sbQ.pop_front();
            checkOutput("missing rvalid", 256'(0), 256'(1));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word3 = {{31{8'hA5}}, 8'h11};
        word1 = {8{32'h1234_5678}};
        word8 = {128'h0, {16{8'h3C}}};
`ifdef RAM_RESPONDER_WR_FWD_EN
        collideExp = '1;
`else
        collideExp = '0;
`endif
        reset = 1'b0;
        rden  = 1'b0;
        wren  = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready", 256'(ready), 256'(0));
        checkOutput("reset rvalid", 256'(rvalid), 256'(0));
        checkOutput("reset readData", readData, 256'(0));
        checkOutput("reset err", 256'(err), 256'(0));

        // Release reset while hammering requests that INIT must ignore.
        @(posedge clk);
        #1;
        reset = 1'b1;
        rden  = 1'b1;
        wren  = 1'b1;
        addr  = 14'd300;
        be    = '1;
        wdata = '1;
        initCycles = 0;
        @(negedge clk);
        while (ready !== 1'b1 && initCycles < 400) begin
            initCycles++;
            if (initCycles == 120) addr = 14'd2;
            if (initCycles == 250) begin
                rden = 1'b0;
                wren = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("init length", 256'(initCycles), 256'(DEPTH));
        checkOutput("err after ignored", 256'(err), 256'(0));

        applyStimulus(1'b1, 1'b0, 14'd5, '0, '0, 256'(0));
        applyStimulus(1'b1, 1'b0, 14'd2, '0, '0, 256'(0));
        applyStimulus(1'b0, 1'b1, 14'd3, 32'hFFFF_FFFF, {32{8'hA5}}, '0);
        applyStimulus(1'b0, 1'b1, 14'd3, 32'h0000_0001, {32{8'h11}}, '0);
        applyStimulus(1'b0, 1'b1, 14'd1, 32'hFFFF_FFFF, word1, '0);
        applyStimulus(1'b1, 1'b0, 14'd1, '0, '0, word1);
        applyStimulus(1'b1, 1'b0, 14'd2, '0, '0, 256'(0));
        applyStimulus(1'b1, 1'b0, 14'd3, '0, '0, word3);
        applyStimulus(1'b1, 1'b1, 14'd7, 32'hFFFF_FFFF, '1, collideExp);
        applyStimulus(1'b1, 1'b0, 14'd7, '0, '0, '1);
        applyStimulus(1'b0, 1'b1, 14'd8, 32'h0000_FFFF, {32{8'h3C}}, '0);
        applyStimulus(1'b1, 1'b0, 14'd8, '0, '0, word8);
        idle(LAT + 3);
        checkOutput("err before range", 256'(err), 256'(0));

        applyStimulus(1'b0, 1'b1, 14'd300, 32'hFFFF_FFFF, '1, '0);
        idle(1);
        @(negedge clk);
        checkOutput("err after range write", 256'(err), 256'(1));
        applyStimulus(1'b1, 1'b0, 14'd300, '0, '0, 256'(0));
        applyStimulus(1'b1, 1'b0, 14'd44, '0, '0, 256'(0));
        applyStimulus(1'b1, 1'b0, 14'd3, '0, '0, word3);
        idle(LAT + 4);
        @(negedge clk);
        checkOutput("readData hold", readData, word3);
        checkOutput("err sticky", 256'(err), 256'(1));
        checkOutput("queue drained", 256'(sbQ.size()), 256'(0));

        // A read in flight when reset hits must never produce a pulse.
        @(posedge clk);
        #1;
        rden = 1'b1;
        addr = 14'd3;
        @(posedge clk);
        #1;
        rden  = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrun reset ready", 256'(ready), 256'(0));
        checkOutput("midrun reset err", 256'(err), 256'(0));
        checkOutput("midrun reset readData", readData, 256'(0));
        repeat (LAT + 2) @(posedge clk);
        #1;
        reset = 1'b1;
        waitInit();
        applyStimulus(1'b1, 1'b0, 14'd3, '0, '0, 256'(0));
        applyStimulus(1'b1, 1'b0, 14'd7, '0, '0, 256'(0));
        idle(LAT + 3);
        @(negedge clk);
        checkOutput("final queue drained", 256'(sbQ.size()), 256'(0));
        checkOutput("final err", 256'(err), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
